// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered hex digits with decimal
// points, blanking, leading-zero suppression and PWM brightness per digit slot.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 32768,
   parameter int BRIGHT_W   = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int SLOT_W = $clog2(SCAN_DIV);
   localparam int DIG_W  = $clog2(NUM_DIGITS);

   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic                  DP_OFF    = ACTIVE_LOW;

   logic [SLOT_W-1:0]     slot_reg;
   logic [DIG_W-1:0]      digit_reg;
   logic                  frame_done_reg;

   logic [4*NUM_DIGITS-1:0] pend_data_reg, act_data_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
   logic [NUM_DIGITS-1:0]   pend_blank_reg, act_blank_reg;

   logic [6:0]            seg_reg, seg_next;
   logic [NUM_DIGITS-1:0] an_reg, an_next;
   logic                  dp_reg, dp_next;

   logic slot_wrap;
   logic boundary;

   assign slot_wrap = (slot_reg == SLOT_LAST);
   assign boundary  = slot_wrap && (digit_reg == DIG_LAST);

   // Scan counters and frame pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_reg       <= '0;
         digit_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         slot_reg       <= slot_wrap ? '0 : slot_reg + 1'b1;
         frame_done_reg <= boundary;
         if (slot_wrap)
            digit_reg <= (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
      end
   end

   // A load on the boundary cycle bypasses pending so the sample lands in this frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_data_reg  <= '0;
         pend_dp_reg    <= '0;
         pend_blank_reg <= '0;
         act_data_reg   <= '0;
         act_dp_reg     <= '0;
         act_blank_reg  <= '0;
      end else begin
         if (load) begin
            pend_data_reg  <= data_in;
            pend_dp_reg    <= dp_in;
            pend_blank_reg <= blank_in;
         end
         if (boundary) begin
            act_data_reg  <= load ? data_in  : pend_data_reg;
            act_dp_reg    <= load ? dp_in    : pend_dp_reg;
            act_blank_reg <= load ? blank_in : pend_blank_reg;
         end
      end
   end

   logic [NUM_DIGITS-1:0] upper_zero;
   logic [NUM_DIGITS-1:0] suppress;
   logic [NUM_DIGITS-1:0] onehot;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi = gi + 1) begin : g_digit
         assign upper_zero[gi] = ~|act_data_reg[4*NUM_DIGITS-1:4*gi];
         assign onehot[gi]     = (digit_reg == DIG_W'(gi));
         if (gi == 0) begin : g_first
            assign suppress[gi] = 1'b0;
         end else begin : g_upper
            assign suppress[gi] = lz_suppress & upper_zero[gi] & ~act_dp_reg[gi];
         end
      end
   endgenerate

   // Segment patterns in the asserted-low view, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg_n(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [3:0] cur_nibble;
   logic       bright_on;
   logic       cur_dark;

   assign cur_nibble = act_data_reg[{digit_reg, 2'b00} +: 4];
   assign bright_on  = brightness > slot_reg[SLOT_W-1 -: BRIGHT_W];
   assign cur_dark   = ~bright_on | act_blank_reg[digit_reg] | suppress[digit_reg];

   always_comb begin
      seg_next = SEG_OFF;
      an_next  = AN_OFF;
      dp_next  = DP_OFF;
      if (!cur_dark) begin
         seg_next = hex_to_seg_n(cur_nibble) ^ {7{~ACTIVE_LOW}};
         an_next  = onehot ^ AN_OFF;
         dp_next  = act_dp_reg[digit_reg] ^ DP_OFF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_reg <= SEG_OFF;
         an_reg  <= AN_OFF;
         dp_reg  <= DP_OFF;
      end else begin
         seg_reg <= seg_next;
         an_reg  <= an_next;
         dp_reg  <= dp_next;
      end
   end

   assign seg        = seg_reg;
   assign an         = an_reg;
   assign dp         = dp_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness,
// active-low pins): per-cycle pin checks over whole frames.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_suppress;
   logic [1:0]  brightness;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seg7_scan_ctrl #(
      .NUM_DIGITS(4),
      .SCAN_DIV  (16),
      .BRIGHT_W  (2),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_suppress(lz_suppress),
      .brightness (brightness),
      .load       (load),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dpi;
      logic [3:0]  blank;
      logic        lz;
      logic [1:0]  bright;
      logic [3:0]  lit;    // digits that light during bright-on slots
      logic [27:0] segs;   // {d3,d2,d1,d0} expected seg pins
      logic [3:0]  dpx;    // expected dp pin per lit digit
   } vec_t;

   vec_t vecs[8];

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S8 = 7'b0000000, SA = 7'b0001000, SC = 7'b1000110,
                          SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110,
                          SX = 7'b1111111;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                             input logic lz, input logic [1:0] br);
      data_in     = d;
      dp_in       = p;
      blank_in    = b;
      lz_suppress = lz;
      brightness  = br;
      load        = 1'b1;
      tick();
      load        = 1'b0;
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!frame_done && n < 200);
      checks++;
      if (!frame_done) begin
         errors++;
         $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
      end
   endtask

   // Call at the sample where frame_done is high; checks the 64 following samples.
   task automatic check_frame(input int tag, input logic [3:0] lit, input logic [27:0] segs,
                              input logic [3:0] dpx, input logic [1:0] br,
                              input int load_at, input logic [15:0] ld_data);
      int fd_early = 0;
      for (int i = 0; i < 64; i++) begin
         int d, s;
         logic [11:0] exp_v;
         if (i == load_at) begin
            data_in = ld_data;
            load    = 1'b1;
         end
         tick();
         load = 1'b0;
         d = i / 16;
         s = i % 16;
         if (lit[d] && (s / 4) < int'(br))
            exp_v = {~(4'b0001 << d), segs[d*7 +: 7], dpx[d]};
         else
            exp_v = {4'hF, 7'h7F, 1'b1};
         checks++;
         if ({an, seg, dp} !== exp_v) begin
            errors++;
            $display("FAIL pixel t%0d cyc=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     tag, i, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
         end
         if (i < 63 && frame_done) fd_early++;
      end
      checks++;
      if (frame_done !== 1'b1 || fd_early != 0) begin
         errors++;
         $display("FAIL frame_period t%0d: frame_done=%b early_pulses=%0d, required 1 and 0",
                  tag, frame_done, fd_early);
      end
      $display("frame t%0d checked: lit=%b bright=%0d", tag, lit, br);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h1A3F, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b1111, {S1, SA, S3, SF}, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0011, {SX, SX, S5, S0}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0001, {SX, SX, SX, S0}, 4'b1111};
      vecs[3] = '{16'h0000, 4'b0100, 4'b0000, 1'b1, 2'd3, 4'b0101, {SX, S0, SX, S0}, 4'b1011};
      vecs[4] = '{16'h1A3F, 4'b0001, 4'b0100, 1'b0, 2'd3, 4'b1011, {S1, SA, S3, SF}, 4'b1110};
      vecs[5] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'b1111, {S1, S2, S3, S4}, 4'b1111};
      vecs[6] = '{16'h8888, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b1111, {S8, S8, S8, S8}, 4'b1111};
      vecs[7] = '{16'hC0DE, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b1111, {SC, S0, SD, SE}, 4'b1111};

      reset       = 1'b1;
      data_in     = '0;
      dp_in       = '0;
      blank_in    = '0;
      lz_suppress = 1'b0;
      brightness  = 2'd3;
      load        = 1'b0;
      tick();
      tick();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got an=%b seg=%b dp=%b fd=%b, required 1111/1111111/1/0",
                  an, seg, dp, frame_done);
      end
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         apply_load(vecs[v].data, vecs[v].dpi, vecs[v].blank, vecs[v].lz, vecs[v].bright);
         wait_frame();
         check_frame(v, vecs[v].lit, vecs[v].segs, vecs[v].dpx, vecs[v].bright, -1, 16'h0);
      end

      // Mid-frame load waits for the next frame; boundary-cycle load takes effect at once.
      apply_load(16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3);
      wait_frame();
      check_frame(10, 4'b1111, {S1, S1, S1, S1}, 4'b1111, 2'd3, 20, 16'h2222);
      check_frame(11, 4'b1111, {S2, S2, S2, S2}, 4'b1111, 2'd3, 63, 16'h3333);
      check_frame(12, 4'b1111, {S3, S3, S3, S3}, 4'b1111, 2'd3, -1, 16'h0);

      // Asynchronous reset while digit 2 is lit.
      for (int i = 0; i < 37; i++) tick();
      checks++;
      if (an !== 4'b1011 || seg !== S3) begin
         errors++;
         $display("FAIL pre_reset_digit2: got an=%b seg=%b, required 1011/%b", an, seg, S3);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got an=%b seg=%b dp=%b fd=%b, required 1111/1111111/1/0",
                  an, seg, dp, frame_done);
      end
      tick();
      reset = 1'b0;
      check_frame(13, 4'b1111, {S0, S0, S0, S0}, 4'b1111, 2'd3, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
